// File: rtl/uart_rx_deser.sv
// Oversampling UART receiver: synchronises rx, deserialises 8N1 frames LSB first, and holds
// byte/frame-error flags until acknowledged. Define UART_RX_PARITY_EN for an even-parity bit.
module uart_rx_deser #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] clk_div,
  input  logic        rx,
  input  logic        i_ctrl_byte_finish,
  output logic [7:0]  o_rx_data,
  output logic        o_byte_finish,
  output logic        o_frame_err,
  output logic        o_rx_busy
);

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 3;
  localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("uart_rx_deser: SYNC_STAGES must be in 2..4");
  end

  state_t              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                rx_prev_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    div_q, div_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   data_d;
  logic                fin_d, err_d, busy_d;
  logic                rx_s, fall;
  logic [CNT_W-1:0]    div_sel, half, last;
  logic                frame_ok;
`ifdef UART_RX_PARITY_EN
  logic                par_ok_q, par_ok_d;
`endif

  // Metastability chain; reset to the idle (high) line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_prev_q <= rx_s;
    end
  end

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign fall    = rx_prev_q & ~rx_s;
  assign div_sel = (clk_div < DIV_MIN) ? DIV_MIN : clk_div;
  assign half    = div_q >> 1;
  assign last    = div_q - CNT_W'(1);

`ifdef UART_RX_PARITY_EN
  assign frame_ok = rx_s & par_ok_q;
`else
  assign frame_ok = rx_s;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      div_q         <= DIV_MIN;
      idx_q         <= '0;
      shift_q       <= '0;
      o_rx_data     <= '0;
      o_byte_finish <= 1'b0;
      o_frame_err   <= 1'b0;
      o_rx_busy     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ok_q      <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      div_q         <= div_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      o_rx_data     <= data_d;
      o_byte_finish <= fin_d;
      o_frame_err   <= err_d;
      o_rx_busy     <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_ok_q      <= par_ok_d;
`endif
    end
  end

  // Next-state and output logic; a flag set later in this block overrides the ack clear
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    div_d   = div_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = o_rx_data;
    fin_d   = o_byte_finish;
    err_d   = o_frame_err;
`ifdef UART_RX_PARITY_EN
    par_ok_d = par_ok_q;
`endif

    if (i_ctrl_byte_finish) begin
      fin_d = 1'b0;
      err_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = START;
          div_d   = div_sel;
        end
      end
      START: begin
        if (cnt_q == half) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == last) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_W-1:1]};
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == last) begin
          cnt_d    = '0;
          par_ok_d = ~(^shift_q ^ rx_s);
          state_d  = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == last) begin
          cnt_d   = '0;
          state_d = DONE;
          fin_d   = 1'b1;
          if (frame_ok) begin
            data_d = shift_q;
            err_d  = 1'b0;
          end else begin
            err_d  = 1'b1;
          end
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule
